// File: rtl/mips_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mux_pkg
//  Description : Shared definitions for the MIPS datapath selection muxes.
//                Holds the occupancy encoding used by the registered mux
//                stage and a clog2 helper so that instantiation sites can
//                derive SEL_W from NUM_IN.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_mux_pkg;

  // Occupancy encoding, also driven directly onto the occupancy port.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Ceiling log2. Returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage : mips_mux_pkg
`default_nettype wire

// File: rtl/mux_n_sel.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n_sel
//  Description : Purely combinational NUM_IN:1 word selector. A select value
//                that does not address an input yields an all-zero word and
//                raises out_of_range.
//  Ports       : in_data      - flattened inputs, input k at [k*WIDTH +: WIDTH]
//                sel          - binary select
//                word         - selected (or zero-filled) word
//                out_of_range - sel >= NUM_IN
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_n_sel #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        word,
  output logic                    out_of_range
);

  // Decoded compare per input rather than an indexed part-select, so an
  // out-of-range select naturally falls through to the zero default.
  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        word = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign out_of_range = (32'(sel) >= 32'(NUM_IN));

endmodule : mux_n_sel
`default_nettype wire

// File: rtl/mux_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pipe_stage
//  Description : N-way, W-bit selection mux with a registered output held in
//                a 2-entry skid buffer (main + skid register) and a
//                valid/ready handshake on both sides. Supports a synchronous
//                flush and flags out-of-range selects with a sticky error.
//  Ports       : clk, reset          - clock, async active-high reset
//                in_data/in_sel      - flattened data inputs and select
//                in_valid/in_ready   - producer handshake (in_ready registered)
//                flush               - discard all buffered words
//                out_data/out_valid  - head of buffer
//                out_ready           - consumer accepts head
//                sel_err             - sticky out-of-range select flag
//                occupancy           - words held (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_pipe_stage
  import mips_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [1:0]              occupancy
);

  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [1:0]       r_occ;
  logic             r_in_ready;
  logic             r_sel_err;

  logic [WIDTH-1:0] w_word;
  logic             w_oor;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [1:0]       w_occ_nxt;
  logic             w_main_we;
  logic             w_main_from_skid;
  logic             w_skid_we;

  mux_n_sel #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .in_data      (in_data),
    .sel          (in_sel),
    .word         (w_word),
    .out_of_range (w_oor)
  );

  assign out_valid  = (r_occ != OCC_EMPTY);
  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // Next occupancy and register write enables. Flush wins over everything:
  // nothing is written and the buffer empties, even if the consumer is
  // taking the head word in the same cycle.
  always_comb begin
    w_occ_nxt        = r_occ;
    w_main_we        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_we        = 1'b0;
    if (flush) begin
      w_occ_nxt = OCC_EMPTY;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (w_in_xfer) begin
            w_main_we = 1'b1;
            w_occ_nxt = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_in_xfer && !w_out_xfer) begin
            w_skid_we = 1'b1;
            w_occ_nxt = OCC_FULL;
          end else if (w_in_xfer && w_out_xfer) begin
            w_main_we = 1'b1;
          end else if (w_out_xfer) begin
            w_occ_nxt = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only the skid->main move can happen.
          if (w_out_xfer) begin
            w_main_we        = 1'b1;
            w_main_from_skid = 1'b1;
            w_occ_nxt        = OCC_ONE;
          end
        end
        default: begin
          w_occ_nxt = OCC_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_occ      <= OCC_EMPTY;
      r_in_ready <= 1'b1;
      r_sel_err  <= 1'b0;
    end else begin
      r_occ      <= w_occ_nxt;
      // Registered from the next occupancy so that in_ready never has a
      // combinational path from out_ready.
      r_in_ready <= (w_occ_nxt != OCC_FULL);
      if (w_main_we) begin
        r_main <= w_main_from_skid ? r_skid : w_word;
      end
      if (w_skid_we) begin
        r_skid <= w_word;
      end
      if (w_in_xfer && !flush && w_oor) begin
        r_sel_err <= 1'b1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_data  = r_main;
  assign sel_err   = r_sel_err;
  assign occupancy = r_occ;

endmodule : mux_pipe_stage
`default_nettype wire

// File: tb/tb_mux_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_pipe_stage
//  Description : Directed self-checking bench for mux_pipe_stage
//                (WIDTH=32, NUM_IN=3, SEL_W=2). Inputs change and outputs
//                are sampled 1 time unit after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_pipe_stage;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  logic                    clk;
  logic                    reset;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic [1:0]              occupancy;

  int errors;
  int checks;

  mux_pipe_stage #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %b want 0", sel_err); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    reset = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_state: valid=%b occ=%0d rdy=%b want 0/0/1", out_valid, occupancy, in_ready);
    end
  endtask

  task automatic test_basic_select();
    in_data   = {32'h33333333, 32'h22222222, 32'h11111111};
    in_sel    = 2'd1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h22222222) begin
      errors++; $display("FAIL basic_out: valid=%b data=%h want 1/22222222", out_valid, out_data);
    end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL basic_occ1: got %0d want 1", occupancy); end
    step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL basic_drain: valid=%b occ=%0d want 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_sel    = 2'd0;
    in_valid  = 1'b1;
    in_data   = {32'h0, 32'h0, 32'h0000000A};
    step();
    checks++; if (occupancy !== 2'd1 || out_data !== 32'hA) begin
      errors++; $display("FAIL bp_first: occ=%0d data=%h want 1/0000000a", occupancy, out_data);
    end
    in_data = {32'h0, 32'h0, 32'h0000000B};
    step();
    in_data = {32'h0, 32'h0, 32'h0000000C};
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full: occ=%0d rdy=%b want 2/0", occupancy, in_ready);
    end
    step();
    checks++; if (occupancy !== 2'd2 || out_valid !== 1'b1 || out_data !== 32'hA) begin
      errors++; $display("FAIL bp_hold: occ=%0d valid=%b data=%h want 2/1/0000000a", occupancy, out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== 32'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second: data=%h occ=%0d rdy=%b want 0000000b/1/1", out_data, occupancy, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 32'hC || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_third: data=%h valid=%b want 0000000c/1", out_data, out_valid);
    end
    step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL bp_drain: valid=%b occ=%0d want 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_word;
    in_data   = {32'h33333333, 32'h22222222, 32'h11111111};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sel = SEL_W'(i % 3);
      case (i % 3)
        0:       exp_word = 32'h11111111;
        1:       exp_word = 32'h22222222;
        default: exp_word = 32'h33333333;
      endcase
      step();
      checks++; if (out_data !== exp_word || out_valid !== 1'b1 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_%0d: data=%h valid=%b occ=%0d rdy=%b want %h/1/1/1",
                           i, out_data, out_valid, occupancy, in_ready, exp_word);
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: valid=%b want 0", out_valid); end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    in_sel    = 2'd0;
    in_valid  = 1'b1;
    in_data   = {32'h0, 32'h0, 32'h00000100};
    step();
    in_data = {32'h0, 32'h0, 32'h00000200};
    step();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_fill: occ=%0d want 2", occupancy); end
    out_ready = 1'b1;
    flush     = 1'b1;
    in_sel    = 2'd1;
    in_data   = {32'h0, 32'hDEADBEEF, 32'h0};
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state: valid=%b occ=%0d rdy=%b want 0/0/1", out_valid, occupancy, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_no_emit_%0d: valid=%b data=%h want valid 0", i, out_valid, out_data);
      end
    end
    // Input offered with flush while in_ready=1 must be dropped, and an
    // out-of-range select on it must not raise sel_err.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_sel   = 2'd3;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd0 || sel_err !== 1'b0) begin
      errors++; $display("FAIL flush_drop_input: occ=%0d sel_err=%b want 0/0", occupancy, sel_err);
    end
  endtask

  task automatic test_out_of_range();
    in_data   = {32'h33333333, 32'h22222222, 32'h11111111};
    in_sel    = 2'd3;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h0 || sel_err !== 1'b1) begin
      errors++; $display("FAIL oor_capture: valid=%b data=%h sel_err=%b want 1/00000000/1", out_valid, out_data, sel_err);
    end
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    checks++; if (sel_err !== 1'b1 || occupancy !== 2'd0) begin
      errors++; $display("FAIL oor_sticky: sel_err=%b occ=%0d want 1/0", sel_err, occupancy);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_sel    = 2'd2;
    in_valid  = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL areset_fill: occ=%0d want 2", occupancy); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || sel_err !== 1'b0) begin
      errors++; $display("FAIL areset_immediate: valid=%b occ=%0d rdy=%b sel_err=%b want 0/0/1/0",
                         out_valid, occupancy, in_ready, sel_err);
    end
    step();
    #2;
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL areset_no_emit: valid=%b occ=%0d want 0/0", out_valid, occupancy);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic_select();
    test_backpressure();
    test_streaming();
    test_flush_full();
    test_out_of_range();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_pipe_stage
`default_nettype wire
